// File: rtl/audio_packet_scheduler.sv
// Drains the audio sample buffer into packets of up to four samples, then holds
// each packet for the data-island arbiter until it has been serialized.
module audio_packet_scheduler #(
  parameter int BUFFER_SIZE = 16,
  parameter int BIT_WIDTH   = 16,
  parameter int CHANNELS    = 2,
  parameter int HIGH_WATER  = 12
) (
  input  logic                         clk_pixel,
  input  logic                         reset,
  input  logic [$clog2(BUFFER_SIZE)-1:0] remaining,
  input  logic [BIT_WIDTH-1:0]         audio_head [CHANNELS-1:0],
  output logic                         sample_pop,
  output logic                         packet_request,
  input  logic                         packet_grant,
  input  logic                         packet_done,
  output logic [BIT_WIDTH-1:0]         packet_samples [3:0][CHANNELS-1:0],
  output logic [3:0]                   sample_present,
  output logic [15:0]                  packets_sent,
  output logic                         buffer_high
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GATHER  = 2'd1,
    REQUEST = 2'd2,
    SEND    = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [2:0] count;
  logic [2:0] count_inc;
  logic       buf_empty;

  assign buf_empty = (remaining == '0);

  always_comb begin
    state_next = state;
    sample_pop = 1'b0;
    count_inc  = count;
    case (state)
      IDLE: begin
        if (!buf_empty) state_next = GATHER;
      end
      GATHER: begin
        sample_pop = !buf_empty && (count < 3'd4);
        count_inc  = count + {2'b00, sample_pop};
        // The fourth pop and the hand-off to REQUEST share one edge.
        if (count_inc == 3'd4 || (buf_empty && count != 3'd0)) state_next = REQUEST;
      end
      REQUEST: begin
        if (packet_grant) state_next = SEND;
      end
      SEND: begin
        if (packet_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) sample_pop = 1'b0;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      sample_present <= '0;
      packet_request <= 1'b0;
      packets_sent   <= '0;
      buffer_high    <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
          packet_samples[i][ch] <= '0;
        end
      end
    end else begin
      state          <= state_next;
      packet_request <= (state_next == REQUEST);
      if (32'(remaining) >= HIGH_WATER) buffer_high <= 1'b1;
      case (state)
        IDLE: begin
          // sample_present survives SEND so late readers still see it.
          if (state_next == GATHER) begin
            count          <= '0;
            sample_present <= '0;
          end
        end
        GATHER: begin
          if (sample_pop) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
              packet_samples[count[1:0]][ch] <= audio_head[ch];
            end
            sample_present[count[1:0]] <= 1'b1;
            count                      <= count_inc;
          end
        end
        SEND: begin
          if (packet_done) packets_sent <= packets_sent + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
